i2c_target: RTL and testbench

- Memory-mapped I2C target (slave) for the peripheral bus.
- Receives and transmits up to 4 data bytes per transaction to/from a 32-bit buffer, addressed by a programmable 7-bit own address.
- It is the bus-side counterpart of the I2C controller. Firmware configures it and exchanges data through the same write_i/addr_i/wdata_i/rdata_o register port used by the other bus peripherals.

---
 rtl/i2c_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with a memory-mapped register port: 7-bit programmable address,
// up to 4 received bytes captured into RXD, up to 4 transmit bytes taken from TXD.
module i2c_target #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [6:0]  RST_ADDR    = 7'h42
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        write_i,
   input  logic [3:0]  data_be_i,
   input  logic [4:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe_o,
   output logic        irq_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_RX,
      S_RX_ACK,
      S_TX,
      S_TX_ACK,
      S_WAIT_STOP
   } state_t;

   localparam logic [4:0] A_SAR = 5'h00;
   localparam logic [4:0] A_RXD = 5'h04;
   localparam logic [4:0] A_TXD = 5'h08;
   localparam logic [4:0] A_STA = 5'h0C;
   localparam logic [4:0] A_CTL = 5'h10;

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic scl_s, sda_s, scl_q, sda_q;
   logic scl_rise, scl_fall, start_det, stop_det;

   logic [6:0]  sar;
   logic [1:0]  ctl;
   logic [31:0] txd;
   logic [31:0] rxd;
   logic [2:0]  rx_cnt;
   logic        rx_done, tx_done, ovf;
   logic        busy;
   logic [31:0] sta;

   state_t      state;
   logic [3:0]  bit_cnt;
   logic [6:0]  shift;
   logic [7:0]  byte_in;
   logic [1:0]  tx_idx;
   logic        rw;
   logic        ack_ph;
   logic        ack_drv;
   logic        wr_seen;

   // Synchronizers idle high so that a reset never fabricates a bus edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   assign start_det = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
   assign byte_in   = {shift, sda_s};

   assign busy  = (state != S_IDLE);
   assign sta   = {25'd0, ovf, busy, tx_done, rx_done, rx_cnt};
   assign irq_o = ctl[0] & ctl[1] & (rx_done | tx_done);

   // Firmware-only registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sar <= RST_ADDR;
         ctl <= 2'b00;
         txd <= 32'd0;
      end else if (write_i) begin
         if (addr_i == A_SAR && data_be_i[0]) sar <= wdata_i[6:0];
         if (addr_i == A_CTL && data_be_i[0]) ctl <= wdata_i[1:0];
         if (addr_i == A_TXD) begin
            for (int b = 0; b < 4; b++) begin
               if (data_be_i[b]) txd[8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Bus FSM plus status/RX registers. W1C clears come first so a
   // hardware set later in the same cycle overrides them.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= S_IDLE;
         bit_cnt  <= 4'd7;
         shift    <= 7'd0;
         tx_idx   <= 2'd0;
         rw       <= 1'b0;
         ack_ph   <= 1'b0;
         ack_drv  <= 1'b0;
         wr_seen  <= 1'b0;
         sda_oe_o <= 1'b0;
         rxd      <= 32'd0;
         rx_cnt   <= 3'd0;
         rx_done  <= 1'b0;
         tx_done  <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (write_i && addr_i == A_STA && data_be_i[0]) begin
            if (wdata_i[3]) rx_done <= 1'b0;
            if (wdata_i[4]) tx_done <= 1'b0;
            if (wdata_i[6]) ovf     <= 1'b0;
         end

         if (start_det) begin
            state    <= S_ADDR;
            bit_cnt  <= 4'd7;
            sda_oe_o <= 1'b0;
         end else if (stop_det) begin
            state    <= S_IDLE;
            sda_oe_o <= 1'b0;
            wr_seen  <= 1'b0;
            if (wr_seen) rx_done <= 1'b1;
         end else begin
            case (state)
               S_ADDR: begin
                  if (scl_rise) begin
                     shift   <= byte_in[6:0];
                     bit_cnt <= bit_cnt - 4'd1;
                     if (bit_cnt == 4'd0) begin
                        if (byte_in[7:1] == sar && ctl[0]) begin
                           state  <= S_ADDR_ACK;
                           rw     <= byte_in[0];
                           ack_ph <= 1'b0;
                           if (!byte_in[0]) wr_seen <= 1'b1;
                        end else begin
                           state <= S_WAIT_STOP;
                        end
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (scl_fall) begin
                     if (!ack_ph) begin
                        sda_oe_o <= 1'b1;
                        ack_ph   <= 1'b1;
                     end else if (rw) begin
                        state    <= S_TX;
                        tx_idx   <= 2'd0;
                        bit_cnt  <= 4'd7;
                        sda_oe_o <= ~txd[7];
                     end else begin
                        state    <= S_RX;
                        rx_cnt   <= 3'd0;
                        bit_cnt  <= 4'd7;
                        sda_oe_o <= 1'b0;
                     end
                  end
               end
               S_RX: begin
                  if (scl_rise) begin
                     shift   <= byte_in[6:0];
                     bit_cnt <= bit_cnt - 4'd1;
                     if (bit_cnt == 4'd0) begin
                        state  <= S_RX_ACK;
                        ack_ph <= 1'b0;
                        if (rx_cnt < 3'd4) begin
                           rxd[{rx_cnt[1:0], 3'b000} +: 8] <= byte_in;
                           rx_cnt  <= rx_cnt + 3'd1;
                           ack_drv <= 1'b1;
                        end else begin
                           ovf     <= 1'b1;
                           ack_drv <= 1'b0;
                        end
                     end
                  end
               end
               S_RX_ACK: begin
                  if (scl_fall) begin
                     if (!ack_ph) begin
                        sda_oe_o <= ack_drv;
                        ack_ph   <= 1'b1;
                     end else begin
                        sda_oe_o <= 1'b0;
                        state    <= S_RX;
                        bit_cnt  <= 4'd7;
                     end
                  end
               end
               S_TX: begin
                  // bit_cnt underflows to 4'hF after the 8th rise, marking the byte end.
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt - 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt[3]) begin
                        sda_oe_o <= 1'b0;
                        state    <= S_TX_ACK;
                     end else begin
                        sda_oe_o <= ~txd[{tx_idx, bit_cnt[2:0]}];
                     end
                  end
               end
               S_TX_ACK: begin
                  if (scl_rise) begin
                     if (!sda_s) begin
                        tx_idx  <= tx_idx + 2'd1;
                        bit_cnt <= 4'd7;
                        state   <= S_TX;
                     end else begin
                        tx_done <= 1'b1;
                        state   <= S_WAIT_STOP;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rdata_o <= 32'd0;
      end else begin
         case (addr_i)
            A_SAR:   rdata_o <= {25'd0, sar};
            A_RXD:   rdata_o <= rxd;
            A_TXD:   rdata_o <= txd;
            A_STA:   rdata_o <= sta;
            A_CTL:   rdata_o <= {30'd0, ctl};
            default: rdata_o <= 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: register vector table, then hand-built I2C
// controller sequences over an open-drain SDA model.
`timescale 1ns/1ps
module tb_i2c_target;

   logic        clk;
   logic        rst_n;
   logic        write;
   logic [3:0]  be;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        scl;
   logic        sda_drv;
   logic        sda_line;
   logic        sda_oe;
   logic        irq;

   int n_vec = 0;
   int n_bad = 0;

   logic mon_en  = 1'b0;
   logic oe_seen = 1'b0;

   assign sda_line = sda_drv & ~sda_oe;

   i2c_target dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .write_i   (write),
      .data_be_i (be),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .rdata_o   (rdata),
      .scl_i     (scl),
      .sda_i     (sda_line),
      .sda_oe_o  (sda_oe),
      .irq_o     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (mon_en && sda_oe) oe_seen = 1'b1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic        do_wr;
      logic [4:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp;
   } reg_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic reg_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      write = 1'b1; addr = a; wdata = d; be = b;
      @(negedge clk);
      write = 1'b0; be = 4'h0;
   endtask

   task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a;
      @(negedge clk);
      d = rdata;
   endtask

   task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] d;
      reg_read(a, d);
      check(name, d, exp);
   endtask

   task automatic send_bit(input logic b, output logic s);
      sda_drv = b;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(4);
      s = sda_line;
      wait_clk(4);
      scl = 1'b0;
      wait_clk(6);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(6);
      sda_drv = 1'b0;
      wait_clk(6);
      scl = 1'b0;
      wait_clk(6);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(6);
      sda_drv = 1'b1;
      wait_clk(6);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(d[i], s);
      send_bit(1'b1, s);
      acked = ~s;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
      send_bit(~ack, s);
   endtask

   reg_vec_t    vecs [15];
   logic        ack;
   logic        s;
   logic [7:0]  rb;
   logic [7:0]  tx_bytes [4];

   initial begin
      vecs[0]  = '{1'b0, 5'h00, 4'h0, 32'h0000_0000, 32'h0000_0042};
      vecs[1]  = '{1'b0, 5'h04, 4'h0, 32'h0000_0000, 32'h0000_0000};
      vecs[2]  = '{1'b0, 5'h08, 4'h0, 32'h0000_0000, 32'h0000_0000};
      vecs[3]  = '{1'b0, 5'h0C, 4'h0, 32'h0000_0000, 32'h0000_0000};
      vecs[4]  = '{1'b0, 5'h10, 4'h0, 32'h0000_0000, 32'h0000_0000};
      vecs[5]  = '{1'b1, 5'h08, 4'h5, 32'hDEAD_BEEF, 32'h00AD_00EF};
      vecs[6]  = '{1'b1, 5'h00, 4'h1, 32'hFFFF_FFFF, 32'h0000_007F};
      vecs[7]  = '{1'b1, 5'h00, 4'hE, 32'h0000_0042, 32'h0000_007F};
      vecs[8]  = '{1'b1, 5'h00, 4'hF, 32'h0000_0042, 32'h0000_0042};
      vecs[9]  = '{1'b1, 5'h14, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[10] = '{1'b1, 5'h04, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[11] = '{1'b1, 5'h10, 4'h1, 32'h0000_00FF, 32'h0000_0003};
      vecs[12] = '{1'b1, 5'h0C, 4'h1, 32'h0000_00FF, 32'h0000_0000};
      vecs[13] = '{1'b1, 5'h10, 4'hF, 32'h0000_0000, 32'h0000_0000};
      vecs[14] = '{1'b1, 5'h08, 4'hF, 32'h4433_2211, 32'h4433_2211};
      tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33; tx_bytes[3] = 8'h44;

      rst_n = 1'b0; write = 1'b0; be = 4'h0; addr = 5'h00; wdata = 32'd0;
      scl = 1'b1; sda_drv = 1'b1;
      wait_clk(3);
      check("reset_rdata", rdata, 32'd0);
      check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;
      wait_clk(2);

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].do_wr) reg_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
         check_reg($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // Write of two bytes.
      reg_write(5'h10, 32'h3, 4'h1);
      i2c_start();
      check_reg("t1_busy", 5'h0C, 32'h20);
      write_byte(8'h84, ack); check("t1_addr_ack", {31'd0, ack}, 32'd1);
      write_byte(8'hA1, ack); check("t1_b0_ack", {31'd0, ack}, 32'd1);
      write_byte(8'hB2, ack); check("t1_b1_ack", {31'd0, ack}, 32'd1);
      i2c_stop();
      check_reg("t1_rxd", 5'h04, 32'h0000_B2A1);
      check_reg("t1_sta", 5'h0C, 32'h0A);
      check("t1_irq", {31'd0, irq}, 32'd1);
      reg_write(5'h0C, 32'h58, 4'h1);
      check_reg("t1_sta_clr", 5'h0C, 32'h02);
      check("t1_irq_clr", {31'd0, irq}, 32'd0);

      // Five bytes: the fifth overflows.
      i2c_start();
      write_byte(8'h84, ack); check("t2_addr_ack", {31'd0, ack}, 32'd1);
      for (int k = 1; k <= 5; k++) begin
         write_byte(8'(k), ack);
         check($sformatf("t2_b%0d_ack", k), {31'd0, ack}, (k <= 4) ? 32'd1 : 32'd0);
      end
      i2c_stop();
      check_reg("t2_rxd", 5'h04, 32'h0403_0201);
      check_reg("t2_sta", 5'h0C, 32'h4C);
      reg_write(5'h0C, 32'h58, 4'h1);
      check_reg("t2_sta_clr", 5'h0C, 32'h04);

      // Reads: 4 bytes ending with NACK, then 5 bytes showing the wrap.
      for (int n = 4; n <= 5; n++) begin
         i2c_start();
         write_byte(8'h85, ack); check($sformatf("t3_%0d_addr_ack", n), {31'd0, ack}, 32'd1);
         for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, rb);
            check($sformatf("t3_%0d_byte%0d", n, k), {24'd0, rb}, {24'd0, tx_bytes[k % 4]});
         end
         i2c_stop();
         check_reg($sformatf("t3_%0d_sta", n), 5'h0C, 32'h14);
         reg_write(5'h0C, 32'h58, 4'h1);
      end

      // Address mismatch, then own address with enable cleared.
      oe_seen = 1'b0; mon_en = 1'b1;
      i2c_start();
      write_byte(8'h90, ack); check("t4_addr_nack", {31'd0, ack}, 32'd0);
      write_byte(8'h12, ack); check("t4_data_nack", {31'd0, ack}, 32'd0);
      i2c_stop();
      reg_write(5'h10, 32'h2, 4'h1);
      i2c_start();
      write_byte(8'h84, ack); check("t4_dis_nack", {31'd0, ack}, 32'd0);
      i2c_stop();
      mon_en = 1'b0;
      check("t4_oe_never", {31'd0, oe_seen}, 32'd0);
      check_reg("t4_sta", 5'h0C, 32'h04);
      reg_write(5'h10, 32'h3, 4'h1);

      // Repeated START: write one byte, Sr, read one byte.
      i2c_start();
      write_byte(8'h84, ack); check("t5_waddr_ack", {31'd0, ack}, 32'd1);
      write_byte(8'h5A, ack); check("t5_data_ack", {31'd0, ack}, 32'd1);
      i2c_start();
      write_byte(8'h85, ack); check("t5_raddr_ack", {31'd0, ack}, 32'd1);
      read_byte(1'b0, rb);
      check("t5_read", {24'd0, rb}, 32'h11);
      check_reg("t5_sta_pre_stop", 5'h0C, 32'h31);
      i2c_stop();
      check_reg("t5_sta", 5'h0C, 32'h19);
      check_reg("t5_rxd", 5'h04, 32'h0403_025A);

      // W1C of rx_done landing on the same cycle the STOP is detected.
      i2c_start();
      write_byte(8'h84, ack); check("t6_addr_ack", {31'd0, ack}, 32'd1);
      write_byte(8'h77, ack); check("t6_data_ack", {31'd0, ack}, 32'd1);
      sda_drv = 1'b0;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(6);
      sda_drv = 1'b1;
      wait_clk(2);
      write = 1'b1; addr = 5'h0C; wdata = 32'h08; be = 4'h1;
      wait_clk(1);
      write = 1'b0; be = 4'h0;
      wait_clk(4);
      check_reg("t6_sta_set_wins", 5'h0C, 32'h19);
      reg_write(5'h0C, 32'h18, 4'h1);
      check_reg("t6_sta_clr", 5'h0C, 32'h01);
      check("t6_irq_clr", {31'd0, irq}, 32'd0);

      // Reset while the address ACK is being driven.
      reg_write(5'h00, 32'h21, 4'h1);
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(i == 6 || i == 1, s);
      check("t7_ack_driven", {31'd0, sda_oe}, 32'd1);
      rst_n = 1'b0;
      wait_clk(1);
      check("t7_oe_released", {31'd0, sda_oe}, 32'd0);
      scl = 1'b1; sda_drv = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);
      check_reg("t7_sta", 5'h0C, 32'h00);
      check_reg("t7_sar", 5'h00, 32'h42);
      check_reg("t7_ctl", 5'h10, 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
